window_streamer: RTL and testbench
==================================

WINDOW_STREAMER -- requirements
Module: window_streamer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning bits per pixel (1..16).
REQ-002 SHALL have parameter KERNEL_SIZE, default 3, meaning window side K; odd, 3..7; R=(K-1)/2.
REQ-003 SHALL have parameter IMAGE_WIDTH, default 512, meaning pixels per row W (W > K).
REQ-004 SHALL have parameter IMAGE_HEIGHT, default 512, meaning rows per frame H (H > K).
REQ-005 SHALL have parameter PAD_VALUE, default 0, meaning the DATA_WIDTH value substituted for out-of-frame window elements.
REQ-006 SHALL have port i_clk, input, 1, meaning the single clock; all logic rising-edge.
REQ-007 SHALL have port i_reset_n, input, 1, meaning reset: asynchronous, active-low.
REQ-008 SHALL have port i_pixel_data, input, DATA_WIDTH, meaning the raster-order pixel.
REQ-009 SHALL have port i_pixel_valid, input, 1, meaning i_pixel_data is valid.
REQ-010 SHALL have port o_pixel_ready, output, 1, meaning the block accepts a pixel this cycle.
REQ-011 SHALL have port o_window, output, K*K*DATA_WIDTH, meaning the window; element (dr,dc) at bits [(dr*K+dc)*DATA_WIDTH +: DATA_WIDTH], with dr=0 the top row and dc=0 the left column.
REQ-012 SHALL have port o_window_valid, output, 1, meaning o_window and the flags are valid.
REQ-013 SHALL have port i_window_ready, input, 1, meaning downstream accepts the window.
REQ-014 SHALL have port o_sof, output, 1, meaning the current window is centred at (0,0).
REQ-015 SHALL have port o_eof, output, 1, meaning the current window is centred at (H-1,W-1).

Function
REQ-016 SHALL accept a pixel on each cycle where i_pixel_valid && o_pixel_ready, and SHALL otherwise hold all state.
REQ-017 SHALL have an FSM with states FILL, STREAM and DRAIN: FILL until input index R*W+R is accepted; STREAM until index W*H-1 is accepted; DRAIN for exactly R*W+R internal shift steps, then FILL for the next frame.
REQ-018 SHALL store the rows with K-1 line buffers of depth W plus a K x K register array, shifting once per accepted pixel or per DRAIN step; a DRAIN step shifts in PAD_VALUE.
REQ-019 SHALL emit exactly one window per frame pixel, in raster order of centre (r,c), W*H windows per frame.
REQ-020 SHALL produce the window for centre index n = r*W+c on the shift caused by input index n+R*W+R (STREAM), or by the corresponding DRAIN step, and present it registered on the next cycle.
REQ-021 SHALL replace with PAD_VALUE each element whose source row r+dr-R lies outside 0..H-1 or whose source column c+dc-R lies outside 0..W-1; no element from a horizontally wrapped row SHALL appear.
REQ-022 SHALL track centre row/column counters that wrap at W-1 and H-1, and SHALL drive the padding mask from them; the masks SHALL NOT depend on line-buffer contents, so line buffers need no reset.
REQ-023 SHALL drive o_pixel_ready = (state != DRAIN) && (!o_window_valid || i_window_ready).
REQ-024 SHALL advance DRAIN steps only when (!o_window_valid || i_window_ready).
REQ-025 SHALL hold o_window, o_sof and o_eof stable while o_window_valid && !i_window_ready.
REQ-026 SHALL deassert o_window_valid after a handshake unless a new window is loaded in the same cycle, which supports back-to-back transfers at 1 window per cycle.
REQ-027 SHALL accept the first pixel of frame k+1 the cycle after the last DRAIN step of frame k, with no bubble other than DRAIN.

Reset
REQ-028 SHALL, on i_reset_n=0 (asynchronous), set the state to FILL, zero all counters and drive o_window_valid=0, o_sof=0, o_eof=0 and o_window=0; o_pixel_ready SHALL be 1 from the first cycle after release.
REQ-029 SHALL, on reset mid-frame, discard the partial frame and treat the next accepted pixel as (0,0) of a new frame.

Verification (DATA_WIDTH=8, K=3, W=4, H=3, PAD_VALUE=0, pixels 1..12, unless stated)
REQ-030 SHALL be tested as follows: stream 1..12 with continuous valid/ready -> first window appears the cycle after pixel 6 is accepted = {0,0,0, 0,1,2, 0,5,6} with o_sof=1.
REQ-031 SHALL be tested as follows: same stream -> window for centre (1,0) = {0,1,2, 0,5,6, 0,9,10}; the last window = {7,8,0, 11,12,0, 0,0,0} with o_eof=1; total 12 windows; o_pixel_ready=0 for exactly 5 DRAIN steps.
REQ-032 SHALL be tested as follows: PAD_VALUE=8'hFF -> window for centre (0,0) = {FF,FF,FF, FF,1,2, FF,5,6}.
REQ-033 SHALL be tested as follows: random i_window_ready and i_pixel_valid throttling -> an identical window sequence, no loss or duplication, and o_window stable during stalls.
REQ-034 SHALL be tested as follows: two back-to-back frames with the second frame using pixels 101..112 -> the second frame's first window = {0,0,0, 0,101,102, 0,105,106}, with no frame-1 data present.
REQ-035 SHALL be tested as follows: reset asserted after pixel 7, then frame 1..12 restarted -> outputs drop low asynchronously and the next frame's output matches REQ-030/REQ-031 exactly.

Source files
------------

// File: rtl/window_streamer.sv
// window_streamer
//   Turns a raster-order pixel stream into K x K neighbourhood windows, one per
//   frame pixel, in raster order of the window centre. Out-of-frame elements are
//   replaced by PAD_VALUE. After the last pixel of a frame the block drains the
//   remaining R*W+R windows by shifting in padding, then starts the next frame.
//
// Ports
//   i_clk          clock, rising edge
//   i_reset_n      asynchronous active-low reset
//   i_pixel_data   input pixel (raster order)
//   i_pixel_valid  i_pixel_data valid
//   o_pixel_ready  pixel accepted this cycle when valid is also high
//   o_window       K*K elements, (dr,dc) at [(dr*K+dc)*DATA_WIDTH +: DATA_WIDTH]
//   o_window_valid o_window / o_sof / o_eof valid
//   i_window_ready downstream accepts the window
//   o_sof          window centred at (0,0)
//   o_eof          window centred at (H-1,W-1)

// One row-delay line: circular buffer, read-before-write at the shared pointer,
// so the word read on a shift is the one written W shifts earlier.
module window_streamer_linebuf #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 512,
  parameter int AW         = 9
) (
  input  logic                  i_clk,
  input  logic                  i_shift,
  input  logic [AW-1:0]         i_ptr,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  assign o_data = r_mem[i_ptr];

  // Contents never need a reset: padding masks come from the centre counters.
  always_ff @(posedge i_clk) begin
    if (i_shift) r_mem[i_ptr] <= i_data;
  end
endmodule

module window_streamer #(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    KERNEL_SIZE  = 3,
  parameter int                    IMAGE_WIDTH  = 512,
  parameter int                    IMAGE_HEIGHT = 512,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE    = '0
) (
  input  logic                                          i_clk,
  input  logic                                          i_reset_n,
  input  logic [DATA_WIDTH-1:0]                         i_pixel_data,
  input  logic                                          i_pixel_valid,
  output logic                                          o_pixel_ready,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] o_window,
  output logic                                          o_window_valid,
  input  logic                                          i_window_ready,
  output logic                                          o_sof,
  output logic                                          o_eof
);
  localparam int K         = KERNEL_SIZE;
  localparam int R         = (K - 1) / 2;
  localparam int W         = IMAGE_WIDTH;
  localparam int H         = IMAGE_HEIGHT;
  localparam int NPIX      = W * H;
  localparam int FILL_LAST = R * W + R;   // input index that yields the first window
  localparam int CW        = $clog2(W);
  localparam int RWD       = $clog2(H);
  localparam int NW        = $clog2(NPIX);
  localparam int WB        = K * K * DATA_WIDTH;

  typedef enum logic [1:0] {S_FILL, S_STREAM, S_DRAIN} state_t;

  state_t                                 r_state;
  logic [NW-1:0]                          r_cnt;     // input index, reused as drain step count
  logic [CW-1:0]                          r_ptr;     // line-buffer pointer
  logic [CW-1:0]                          r_ccol;    // centre of the next emitted window
  logic [RWD-1:0]                         r_crow;
  logic [K-1:0][K-1:0][DATA_WIDTH-1:0]    r_win;     // [dr][dc], unmasked
  logic [WB-1:0]                          r_window;
  logic                                   r_win_vld;
  logic                                   r_sof;
  logic                                   r_eof;

  logic                                   w_adv;
  logic                                   w_accept;
  logic                                   w_drain_step;
  logic                                   w_shift;
  logic                                   w_emit;
  logic [DATA_WIDTH-1:0]                  w_din;
  logic [DATA_WIDTH-1:0]                  w_row_in [K];  // column K-1 feed per window row
  logic [K-1:0][K-1:0][DATA_WIDTH-1:0]    w_win_nxt;
  logic [WB-1:0]                          w_masked;

  // Output slot is free (or being emptied) this cycle.
  assign w_adv         = !r_win_vld || i_window_ready;
  assign o_pixel_ready = (r_state != S_DRAIN) && w_adv;
  assign w_accept      = i_pixel_valid && o_pixel_ready;
  assign w_drain_step  = (r_state == S_DRAIN) && w_adv;
  assign w_shift       = w_accept || w_drain_step;
  assign w_din         = w_drain_step ? PAD_VALUE : i_pixel_data;
  // Every shift emits a window except the FILL shifts before the first centre is complete.
  assign w_emit        = w_shift && ((r_state != S_FILL) || (r_cnt == NW'(FILL_LAST)));

  // Bottom window row takes the new pixel; row j takes the pixel delayed (K-1-j) rows.
  assign w_row_in[K-1] = w_din;
  for (genvar j = 0; j < K - 1; j++) begin : g_lb
    window_streamer_linebuf #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (W),
      .AW         (CW)
    ) u_lb (
      .i_clk   (i_clk),
      .i_shift (w_shift),
      .i_ptr   (r_ptr),
      .i_data  (w_row_in[j+1]),
      .o_data  (w_row_in[j])
    );
  end

  always_comb begin
    w_win_nxt = r_win;
    for (int dr = 0; dr < K; dr++) begin
      for (int dc = 0; dc < K - 1; dc++) w_win_nxt[dr][dc] = r_win[dr][dc+1];
      w_win_nxt[dr][K-1] = w_row_in[dr];
    end
  end

  // Padding mask from the centre counters only; this also hides wrapped columns
  // and stale line-buffer rows from an earlier frame.
  always_comb begin
    int rr;
    int cc;
    rr       = 0;
    cc       = 0;
    w_masked = '0;
    for (int dr = 0; dr < K; dr++) begin
      for (int dc = 0; dc < K; dc++) begin
        rr = int'(r_crow) + dr - R;
        cc = int'(r_ccol) + dc - R;
        if (rr >= 0 && rr < H && cc >= 0 && cc < W)
          w_masked[(dr*K+dc)*DATA_WIDTH +: DATA_WIDTH] = w_win_nxt[dr][dc];
        else
          w_masked[(dr*K+dc)*DATA_WIDTH +: DATA_WIDTH] = PAD_VALUE;
      end
    end
  end

  // Window shift register and line-buffer pointer.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_win <= '0;
      r_ptr <= '0;
    end else if (w_shift) begin
      r_win <= w_win_nxt;
      r_ptr <= (r_ptr == CW'(W - 1)) ? '0 : r_ptr + 1'b1;
    end
  end

  // Control FSM, centre counters and registered outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= S_FILL;
      r_cnt     <= '0;
      r_ccol    <= '0;
      r_crow    <= '0;
      r_window  <= '0;
      r_win_vld <= 1'b0;
      r_sof     <= 1'b0;
      r_eof     <= 1'b0;
    end else begin
      case (r_state)
        S_FILL: if (w_accept) begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == NW'(FILL_LAST)) r_state <= S_STREAM;
        end
        S_STREAM: if (w_accept) begin
          if (r_cnt == NW'(NPIX - 1)) begin
            r_cnt   <= '0;
            r_state <= S_DRAIN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DRAIN: if (w_drain_step) begin
          if (r_cnt == NW'(FILL_LAST - 1)) begin
            r_cnt   <= '0;
            r_state <= S_FILL;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_FILL;
      endcase

      if (w_emit) begin
        r_win_vld <= 1'b1;
        r_window  <= w_masked;
        r_sof     <= (r_crow == '0) && (r_ccol == '0);
        r_eof     <= (r_crow == RWD'(H - 1)) && (r_ccol == CW'(W - 1));
        if (r_ccol == CW'(W - 1)) begin
          r_ccol <= '0;
          r_crow <= (r_crow == RWD'(H - 1)) ? '0 : r_crow + 1'b1;
        end else begin
          r_ccol <= r_ccol + 1'b1;
        end
      end else if (i_window_ready) begin
        r_win_vld <= 1'b0;
      end
    end
  end

  assign o_window       = r_window;
  assign o_window_valid = r_win_vld;
  assign o_sof          = r_sof;
  assign o_eof          = r_eof;
endmodule

// File: tb/tb_window_streamer.sv
`timescale 1ns/1ps
module tb_window_streamer;
  localparam int DW = 8, K = 3, W = 4, H = 3, NP = W * H, WB = K * K * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] px = '0;
  logic          pv = 1'b0;
  logic          wr = 1'b0;
  logic          pr, wv, sof, eof;
  logic [WB-1:0] win;
  logic          pr2, wv2, sof2, eof2;
  logic [WB-1:0] win2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  window_streamer #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H),
                    .PAD_VALUE(8'h00)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_pixel_data(px), .i_pixel_valid(pv),
    .o_pixel_ready(pr), .o_window(win), .o_window_valid(wv), .i_window_ready(wr),
    .o_sof(sof), .o_eof(eof));

  window_streamer #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H),
                    .PAD_VALUE(8'hFF)) dut_ff (
    .i_clk(clk), .i_reset_n(rst_n), .i_pixel_data(px), .i_pixel_valid(pv),
    .o_pixel_ready(pr2), .o_window(win2), .o_window_valid(wv2), .i_window_ready(wr),
    .o_sof(sof2), .o_eof(eof2));

  logic [DW-1:0] px_q[$];
  logic [DW-1:0] src[$];
  logic [WB-1:0] exp_w[$], exp_w2[$], got_w[$], got_w2[$];
  bit            exp_s[$], exp_e[$], got_s[$], got_e[$];
  int            acc5_cyc, first_vld_cyc, nrdy_cyc;

  // Element (dr,dc) of the window centred at pixel n of frame f, from the frame image.
  function automatic logic [WB-1:0] ref_win(input int f, input int n, input logic [DW-1:0] pad);
    logic [WB-1:0] w;
    int r, c, rr, cc;
    r = n / W;
    c = n % W;
    w = '0;
    for (int dr = 0; dr < K; dr++)
      for (int dc = 0; dc < K; dc++) begin
        rr = r + dr - K / 2;
        cc = c + dc - K / 2;
        if (rr >= 0 && rr < H && cc >= 0 && cc < W) w[(dr*K+dc)*DW +: DW] = src[f*NP + rr*W + cc];
        else                                         w[(dr*K+dc)*DW +: DW] = pad;
      end
    return w;
  endfunction

  function automatic logic [WB-1:0] mk9(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {a8, a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  task automatic new_test();
    px_q.delete(); src.delete();
  endtask

  task automatic add_frame(input int base, input bit rnd);
    logic [DW-1:0] v;
    for (int i = 0; i < NP; i++) begin
      v = rnd ? 8'($urandom) : 8'(base + i);
      px_q.push_back(v);
      src.push_back(v);
    end
  endtask

  task automatic build_exp();
    exp_w.delete(); exp_w2.delete(); exp_s.delete(); exp_e.delete();
    for (int f = 0; f < src.size() / NP; f++)
      for (int n = 0; n < NP; n++) begin
        exp_w.push_back(ref_win(f, n, 8'h00));
        exp_w2.push_back(ref_win(f, n, 8'hFF));
        exp_s.push_back(n == 0);
        exp_e.push_back(n == NP - 1);
      end
  endtask

  // Drives px_q with throttled valid/ready and records every handshaken window.
  task automatic run(input int vp, input int rp, input int stop_after, input int max_cyc);
    int acc = 0, cyc = 0;
    bit stall = 0;
    logic [WB-1:0] pw;
    logic ps, pe;
    got_w.delete(); got_w2.delete(); got_s.delete(); got_e.delete();
    acc5_cyc = -1; first_vld_cyc = -1; nrdy_cyc = 0;
    forever begin
      @(negedge clk);
      if (px_q.size() > 0 && $urandom_range(99) < vp) begin pv = 1'b1; px = px_q[0]; end
      else begin pv = 1'b0; px = 8'($urandom); end
      wr = ($urandom_range(99) < rp);
      #1;
      if (stall) begin
        checks++;
        if (wv !== 1'b1 || win !== pw || sof !== ps || eof !== pe) begin
          errors++;
          $display("FAIL stall_hold cyc=%0d got v=%b w=%h s=%b e=%b want v=1 w=%h s=%b e=%b",
                   cyc, wv, win, sof, eof, pw, ps, pe);
        end
      end
      stall = wv && !wr; pw = win; ps = sof; pe = eof;
      if (wv && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (!pr) nrdy_cyc++;
      if (wv && wr) begin got_w.push_back(win); got_s.push_back(sof); got_e.push_back(eof); end
      if (wv2 && wr) got_w2.push_back(win2);
      if (pv && pr) begin
        if (acc == 5) acc5_cyc = cyc;
        void'(px_q.pop_front());
        acc++;
      end
      cyc++;
      if ((stop_after > 0 && acc == stop_after) ||
          (stop_after == 0 && px_q.size() == 0 && got_w.size() == exp_w.size())) begin
        @(posedge clk); #1; pv = 1'b0; wr = 1'b0;
        return;
      end
      if (cyc >= max_cyc) begin
        checks++; errors++;
        $display("FAIL timeout got %0d windows want %0d, %0d pixels left", got_w.size(), exp_w.size(), px_q.size());
        @(posedge clk); #1; pv = 1'b0; wr = 1'b0;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pv = 1'b0; wr = 1'b0;
    #12;
    checks++; if (wv !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", wv); end
    checks++; if (sof !== 1'b0 || eof !== 1'b0) begin errors++; $display("FAIL rst_flags got sof=%b eof=%b want 0 0", sof, eof); end
    checks++; if (win !== '0) begin errors++; $display("FAIL rst_window got %h want 0", win); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (pr !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", pr); end
  endtask

  task automatic test_basic();
    new_test(); add_frame(1, 0); build_exp();
    run(100, 100, 0, 200);
    checks++; if (got_w.size() != NP) begin errors++; $display("FAIL basic_count got %0d want %0d", got_w.size(), NP); end
    checks++; if (first_vld_cyc != acc5_cyc + 1) begin errors++; $display("FAIL basic_latency got cyc %0d want %0d", first_vld_cyc, acc5_cyc + 1); end
    checks++; if (got_w[0] !== mk9(0,0,0, 0,1,2, 0,5,6) || got_s[0] !== 1'b1) begin
      errors++; $display("FAIL basic_first got %h sof=%b want %h sof=1", got_w[0], got_s[0], mk9(0,0,0, 0,1,2, 0,5,6)); end
    checks++; if (got_w[4] !== mk9(0,1,2, 0,5,6, 0,9,10)) begin
      errors++; $display("FAIL basic_c10 got %h want %h", got_w[4], mk9(0,1,2, 0,5,6, 0,9,10)); end
    checks++; if (got_w[11] !== mk9(7,8,0, 11,12,0, 0,0,0) || got_e[11] !== 1'b1) begin
      errors++; $display("FAIL basic_last got %h eof=%b want %h eof=1", got_w[11], got_e[11], mk9(7,8,0, 11,12,0, 0,0,0)); end
    checks++; if (nrdy_cyc != 5) begin errors++; $display("FAIL basic_drain got %0d not-ready cycles want 5", nrdy_cyc); end
    for (int i = 0; i < got_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_s[i] !== exp_s[i] || got_e[i] !== exp_e[i]) begin
        errors++; $display("FAIL basic_win[%0d] got %h s=%b e=%b want %h s=%b e=%b", i, got_w[i], got_s[i], got_e[i], exp_w[i], exp_s[i], exp_e[i]);
      end
    end
  endtask

  task automatic test_pad();
    new_test(); add_frame(1, 0); build_exp();
    run(100, 100, 0, 200);
    checks++; if (got_w2[0] !== mk9(8'hFF,8'hFF,8'hFF, 8'hFF,1,2, 8'hFF,5,6)) begin
      errors++; $display("FAIL pad_first got %h want %h", got_w2[0], mk9(8'hFF,8'hFF,8'hFF, 8'hFF,1,2, 8'hFF,5,6)); end
    checks++; if (got_w2.size() != NP) begin errors++; $display("FAIL pad_count got %0d want %0d", got_w2.size(), NP); end
    for (int i = 0; i < got_w2.size(); i++) begin
      checks++;
      if (got_w2[i] !== exp_w2[i]) begin errors++; $display("FAIL pad_win[%0d] got %h want %h", i, got_w2[i], exp_w2[i]); end
    end
  endtask

  task automatic test_throttle();
    new_test(); add_frame(0, 1); add_frame(0, 1); add_frame(0, 1); build_exp();
    run(60, 50, 0, 3000);
    checks++; if (got_w.size() != exp_w.size()) begin errors++; $display("FAIL thr_count got %0d want %0d", got_w.size(), exp_w.size()); end
    for (int i = 0; i < got_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_s[i] !== exp_s[i] || got_e[i] !== exp_e[i]) begin
        errors++; $display("FAIL thr_win[%0d] got %h s=%b e=%b want %h s=%b e=%b", i, got_w[i], got_s[i], got_e[i], exp_w[i], exp_s[i], exp_e[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    new_test(); add_frame(1, 0); add_frame(101, 0); build_exp();
    run(100, 100, 0, 300);
    checks++; if (got_w.size() != 2 * NP) begin errors++; $display("FAIL b2b_count got %0d want %0d", got_w.size(), 2 * NP); end
    checks++; if (got_w[NP] !== mk9(0,0,0, 0,101,102, 0,105,106) || got_s[NP] !== 1'b1) begin
      errors++; $display("FAIL b2b_first2 got %h sof=%b want %h sof=1", got_w[NP], got_s[NP], mk9(0,0,0, 0,101,102, 0,105,106)); end
    checks++; if (nrdy_cyc != 10) begin errors++; $display("FAIL b2b_bubbles got %0d not-ready cycles want 10", nrdy_cyc); end
    for (int i = 0; i < got_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_s[i] !== exp_s[i] || got_e[i] !== exp_e[i]) begin
        errors++; $display("FAIL b2b_win[%0d] got %h s=%b e=%b want %h s=%b e=%b", i, got_w[i], got_s[i], got_e[i], exp_w[i], exp_s[i], exp_e[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    new_test(); add_frame(1, 0); build_exp();
    run(100, 100, 7, 200);
    checks++; if (wv !== 1'b1) begin errors++; $display("FAIL mid_prevalid got %b want 1", wv); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (wv !== 1'b0 || sof !== 1'b0 || eof !== 1'b0 || win !== '0) begin
      errors++; $display("FAIL mid_async got v=%b s=%b e=%b w=%h want all 0", wv, sof, eof, win); end
    #3 rst_n = 1'b1;
    new_test(); add_frame(1, 0); build_exp();
    run(100, 100, 0, 200);
    checks++; if (got_w.size() != NP) begin errors++; $display("FAIL mid_count got %0d want %0d", got_w.size(), NP); end
    checks++; if (got_w[0] !== mk9(0,0,0, 0,1,2, 0,5,6) || got_s[0] !== 1'b1) begin
      errors++; $display("FAIL mid_first got %h sof=%b want %h sof=1", got_w[0], got_s[0], mk9(0,0,0, 0,1,2, 0,5,6)); end
    checks++; if (got_w[11] !== mk9(7,8,0, 11,12,0, 0,0,0) || got_e[11] !== 1'b1) begin
      errors++; $display("FAIL mid_last got %h eof=%b want %h eof=1", got_w[11], got_e[11], mk9(7,8,0, 11,12,0, 0,0,0)); end
    for (int i = 0; i < got_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_s[i] !== exp_s[i] || got_e[i] !== exp_e[i]) begin
        errors++; $display("FAIL mid_win[%0d] got %h s=%b e=%b want %h s=%b e=%b", i, got_w[i], got_s[i], got_e[i], exp_w[i], exp_s[i], exp_e[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pad();
    test_throttle();
    test_back_to_back();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
